// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use interlock unit.
// Entry fields use fixed maximum widths so one packed type serves every parameterisation.
package fwd_pkg;

  localparam int RD_MAX_W  = 8;
  localparam int LAT_MAX_W = 4;

  localparam int SEL_RF    = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [RD_MAX_W-1:0]  rd;
    logic [LAT_MAX_W-1:0] lat;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-producer search for one ID source operand across the in-flight writer entries.
// Entry k sits at distance k+1 from the consumer; entries beyond the forwarding window are ignored.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES+1),
  parameter int LAT_W      = $clog2(FWD_STAGES+2)
) (
  input  logic [REG_AW-1:0] i_src,
  input  fwd_entry_t        i_entries [FWD_STAGES+1],
  output logic              o_hit,
  output logic [SEL_W-1:0]  o_dist,
  output logic [LAT_W-1:0]  o_lat
);

  logic [RD_MAX_W-1:0] w_src;

  assign w_src = RD_MAX_W'(i_src);

  // Scan oldest to youngest so the nearest match overwrites any older one.
  always_comb begin
    o_hit  = 1'b0;
    o_dist = '0;
    o_lat  = '0;
    for (int k = FWD_STAGES; k >= 0; k--) begin
      if ((k + 1) <= FWD_STAGES &&
          i_entries[k].valid && i_entries[k].regwrite &&
          i_entries[k].rd != '0 && i_entries[k].rd == w_src) begin
        o_hit  = 1'b1;
        o_dist = SEL_W'(k + 1);
        o_lat  = LAT_W'(i_entries[k].lat);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use interlock for the in-order pipeline.
// Shadows every writer from EX through the last forwarding stage; stall is combinational, fwd_sel registered.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES+1),
  parameter int LAT_W      = $clog2(FWD_STAGES+2),
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_regwrite,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  fwd_entry_t               r_ent [FWD_STAGES+1];
  logic [NUM_SRC*SEL_W-1:0] r_fwd_sel;
  logic [CNT_W-1:0]         r_stall_cnt;

  logic [NUM_SRC-1:0]       w_hit;
  logic [NUM_SRC-1:0]       w_src_stall;
  logic [SEL_W-1:0]         w_dist [NUM_SRC];
  logic [LAT_W-1:0]         w_lat  [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] w_sel_next;
  logic [LAT_W-1:0]         w_id_lat;
  logic                     w_bubble;

  assign w_id_lat = (id_lat == '0) ? LAT_W'(1) : id_lat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W),
        .LAT_W      (LAT_W)
      ) u_match (
        .i_src     (id_src[gi*REG_AW +: REG_AW]),
        .i_entries (r_ent),
        .o_hit     (w_hit[gi]),
        .o_dist    (w_dist[gi]),
        .o_lat     (w_lat[gi])
      );

      // Result is not on any bus yet when the producer is closer than its latency.
      assign w_src_stall[gi] = id_src_used[gi] & w_hit[gi] &
                               (int'(w_dist[gi]) < int'(w_lat[gi]));
      assign w_sel_next[gi*SEL_W +: SEL_W] = (id_src_used[gi] & w_hit[gi]) ?
                                             w_dist[gi] : SEL_W'(SEL_RF);
    end
  endgenerate

  assign stall    = id_valid & ~flush & (|w_src_stall);
  assign w_bubble = flush | stall | ~id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        r_ent[k] <= '0;
      end
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_ent[k] <= r_ent[k-1];
      end
      if (w_bubble) begin
        r_ent[0]  <= '0;
        r_fwd_sel <= '0;
      end else begin
        r_ent[0]  <= '{valid:    1'b1,
                       regwrite: id_regwrite,
                       rd:       RD_MAX_W'(id_rd),
                       lat:      LAT_MAX_W'(w_id_lat)};
        r_fwd_sel <= w_sel_next;
      end
      if (stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign fwd_sel   = r_fwd_sel;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares stall, stall_cnt and the following cycle's fwd_sel.
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int SEL_W   = 2;
  localparam int LAT_W   = 2;
  localparam int CNT_W   = 32;

  logic                      clk;
  logic                      rst_n;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_regwrite;
  logic [REG_AW-1:0]         id_rd;
  logic [LAT_W-1:0]          id_lat;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_regwrite (id_regwrite),
    .id_rd       (id_rd),
    .id_lat      (id_lat),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          e_stall;
    logic [3:0]  e_sel;
    logic [31:0] e_cnt;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One ID-stage cycle; sel args are the fwd_sel expected while this instruction is in EX.
  task automatic step(input string name, input bit v, input int s0, input int s1,
                      input bit [1:0] used, input bit rw, input int rd, input int lat,
                      input bit fl, input bit e_st, input int e0, input int e1, input int e_cnt);
    exp_t it;
    @(posedge clk);
    #1;
    id_valid    = v;
    id_src      = {REG_AW'(s1), REG_AW'(s0)};
    id_src_used = used;
    id_regwrite = rw;
    id_rd       = REG_AW'(rd);
    id_lat      = LAT_W'(lat);
    flush       = fl;
    it.name     = name;
    it.e_stall  = e_st;
    it.e_sel    = {SEL_W'(e1), SEL_W'(e0)};
    it.e_cnt    = 32'(e_cnt);
    q_exp.push_back(it);
    $display("step %-12s v=%0b src=%0d,%0d used=%b rd=%0d lat=%0d flush=%0b", name, v, s0, s1, used, rd, lat, fl);
  endtask

  task automatic nops(input int n, input int cnt);
    for (int i = 0; i < n; i++) step("nop", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, cnt);
  endtask

  // Monitor: stall/cnt belong to the popped cycle, fwd_sel to the previously popped one.
  initial begin
    exp_t       it;
    logic [3:0] pend_sel;
    bit         pend_v;
    pend_v = 0;
    pend_sel = '0;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        it = q_exp.pop_front();
        chk({it.name, ".stall"}, longint'(stall), longint'(it.e_stall));
        chk({it.name, ".cnt"}, longint'(stall_cnt), longint'(it.e_cnt));
        if (pend_v) chk({it.name, ".fwd_sel"}, longint'(fwd_sel), longint'(pend_sel));
        pend_sel = it.e_sel;
        pend_v   = 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    id_valid = 0; id_src = '0; id_src_used = '0; id_regwrite = 0;
    id_rd = '0; id_lat = '0; flush = 0;
    #12;
    chk("reset.stall", longint'(stall), 0);
    chk("reset.fwd_sel", longint'(fwd_sel), 0);
    chk("reset.cnt", longint'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU producer then dependent consumer
    step("t1_add_r3", 1, 1, 2, 2'b11, 1, 3, 1, 0, 0, 0, 0, 0);
    step("t1_sub", 1, 3, 1, 2'b11, 1, 6, 1, 0, 0, 1, 0, 0);
    nops(3, 0);

    // 2: load-use, one stall cycle then MEM/WB forward
    step("t2_lw_r5", 1, 1, 0, 2'b01, 1, 5, 2, 0, 0, 0, 0, 0);
    step("t2_add_st", 1, 5, 2, 2'b11, 1, 7, 1, 0, 1, 0, 0, 0);
    step("t2_add", 1, 5, 2, 2'b11, 1, 7, 1, 0, 0, 2, 0, 1);
    nops(3, 1);

    // 3: two writers of r4, youngest wins (checked on source 1)
    step("t3_add_a", 1, 1, 2, 2'b11, 1, 4, 1, 0, 0, 0, 0, 1);
    step("t3_add_b", 1, 2, 1, 2'b11, 1, 4, 1, 0, 0, 0, 0, 1);
    step("t3_use", 1, 9, 4, 2'b11, 1, 8, 1, 0, 0, 0, 1, 1);
    nops(3, 1);

    // 4: register 0 never forwards or stalls
    step("t4_w_r0", 1, 1, 2, 2'b11, 1, 0, 2, 0, 0, 0, 0, 1);
    step("t4_use_r0", 1, 0, 0, 2'b11, 1, 1, 1, 0, 0, 0, 0, 1);
    nops(3, 1);

    // 5: flush beats stall; unused source never stalls or forwards
    step("t5_lw_r5", 1, 1, 0, 2'b01, 1, 5, 2, 0, 0, 0, 0, 1);
    step("t5_flush", 1, 5, 0, 2'b01, 1, 2, 1, 1, 0, 0, 0, 1);
    nops(3, 1);
    step("t5_lw_r6", 1, 1, 0, 2'b01, 1, 6, 2, 0, 0, 0, 0, 1);
    step("t5_unused", 1, 1, 6, 2'b01, 1, 2, 1, 0, 0, 0, 0, 1);
    nops(3, 1);

    // 7: never-forwarded result stalls until it leaves the window
    step("t7_lw_lat3", 1, 1, 0, 2'b01, 1, 5, 3, 0, 0, 0, 0, 1);
    step("t7_use_st1", 1, 5, 0, 2'b01, 1, 2, 1, 0, 1, 0, 0, 1);
    step("t7_use_st2", 1, 5, 0, 2'b01, 1, 2, 1, 0, 1, 0, 0, 2);
    step("t7_use", 1, 5, 0, 2'b01, 1, 2, 1, 0, 0, 0, 0, 3);
    nops(3, 3);

    // lat=0 behaves as ALU latency
    step("lat0_prod", 1, 1, 2, 2'b11, 1, 5, 0, 0, 0, 0, 0, 3);
    step("lat0_use", 1, 5, 5, 2'b11, 1, 2, 1, 0, 0, 1, 1, 3);
    nops(3, 3);

    // 6: asynchronous reset in the middle of a load-use stall
    step("t6_lw_r5", 1, 1, 0, 2'b01, 1, 5, 2, 0, 0, 0, 0, 3);
    step("t6_use_st", 1, 5, 0, 2'b01, 1, 2, 1, 0, 1, 0, 0, 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst.stall", longint'(stall), 0);
    chk("t6_rst.fwd_sel", longint'(fwd_sel), 0);
    chk("t6_rst.cnt", longint'(stall_cnt), 0);
    #1;
    rst_n = 1'b1;
    step("t6_after", 1, 5, 0, 2'b01, 1, 2, 1, 0, 0, 0, 0, 0);
    nops(3, 0);

    wait_cyc = 0;
    while (q_exp.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    #1;
    chk("drain", longint'(q_exp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
